// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: two-requester round-robin UART transmitter (8N1, optional even parity).
//
// Bit timing comes only from tick_i, a 16x oversampling strobe; there is no internal divisor.
// Optional feature: define UART_TX_PARITY_EN to add an even-parity bit between DATA and STOP.
//
// Ports:
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   tick_i         one-cycle pulse, 16 per bit period
//   reqN_valid_i   requester N holds a byte (N = 0, 1)
//   reqN_data_i    requester N byte
//   reqN_ready_o   requester N byte accepted this cycle (IDLE only)
//   tx_o           registered serial line, idle high
//   busy_o         frame in progress
//   grant_o        requester index of the current/last frame
module uart_tx_scheduler #(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            tick_i,
    input  logic            req0_valid_i,
    input  logic [DBIT-1:0] req0_data_i,
    output logic            req0_ready_o,
    input  logic            req1_valid_i,
    input  logic [DBIT-1:0] req1_data_i,
    output logic            req1_ready_o,
    output logic            tx_o,
    output logic            busy_o,
    output logic            grant_o
);

    // Counter must reach SB_TICK-1 for multi-stop-bit configurations.
    localparam int unsigned CntW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int unsigned BitW = (DBIT > 1) ? $clog2(DBIT) : 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [BitW-1:0]   bit_q, bit_d;
    logic [DBIT-1:0]   shift_q, shift_d;
    logic              last_q, last_d;
    logic              grant_q, grant_d;
    logic              tx_q, tx_d;
    logic              rdy0, rdy1;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        last_d  = last_q;
        grant_d = grant_q;
        rdy0    = 1'b0;
        rdy1    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            StIdle: begin
                // Gated by reset so no ready is offered while reset is held.
                rdy0 = rst_ni & req0_valid_i & (~req1_valid_i | last_q);
                rdy1 = rst_ni & req1_valid_i & (~req0_valid_i | ~last_q);
                if (rdy0 || rdy1) begin
                    shift_d = rdy0 ? req0_data_i : req1_data_i;
                    last_d  = rdy1;
                    grant_d = rdy1;
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = StStart;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^(rdy0 ? req0_data_i : req1_data_i);
`endif
                end
            end
            StStart: begin
                if (tick_i) begin
                    if (cnt_q == CntW'(15)) begin
                        cnt_d   = '0;
                        state_d = StData;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StData: begin
                if (tick_i) begin
                    if (cnt_q == CntW'(15)) begin
                        cnt_d   = '0;
                        shift_d = shift_q >> 1;
                        if (bit_q == BitW'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
                            state_d = StParity;
`else
                            state_d = StStop;
`endif
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (tick_i) begin
                    if (cnt_q == CntW'(15)) begin
                        cnt_d   = '0;
                        state_d = StStop;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`endif
            StStop: begin
                if (tick_i) begin
                    if (cnt_q == CntW'(SB_TICK - 1)) begin
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Line level follows the next state so tx_o changes on the same edge as the state.
        tx_d = 1'b1;
        unique case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            StParity: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            last_q   <= 1'b1;
            grant_q  <= 1'b0;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign req0_ready_o = rdy0;
    assign req1_ready_o = rdy1;
    assign tx_o         = tx_q;
    assign busy_o       = (state_q != StIdle);
    assign grant_o      = grant_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed stimulus, expected frames queued on issue, a monitor
// reconstructs each frame from tx_o at tick resolution and compares against the queue head.
module tb_uart_tx_scheduler;

`ifdef UART_TX_PARITY_EN
    localparam int FLEN = 176;
`else
    localparam int FLEN = 160;
`endif

    logic       clk_i, rst_ni, tick_i;
    logic       req0_valid_i, req1_valid_i;
    logic [7:0] req0_data_i, req1_data_i;
    logic       req0_ready_o, req1_ready_o, tx_o, busy_o, grant_o;

    uart_tx_scheduler #(.DBIT(8), .SB_TICK(16)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .tick_i       (tick_i),
        .req0_valid_i (req0_valid_i),
        .req0_data_i  (req0_data_i),
        .req0_ready_o (req0_ready_o),
        .req1_valid_i (req1_valid_i),
        .req1_data_i  (req1_data_i),
        .req1_ready_o (req1_ready_o),
        .tx_o         (tx_o),
        .busy_o       (busy_o),
        .grant_o      (grant_o)
    );

    typedef struct {
        logic [7:0] data;
        logic       grant;
        int         len;
        bit         chk_gap;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   tick_en = 1'b1;
    logic [1:0] tick_div = 2'd0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // One tick every 4 clocks, changed just after the rising edge.
    initial begin
        tick_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            tick_div = tick_div + 2'd1;
            tick_i = tick_en && (tick_div == 2'd0);
        end
    end

    // Monitor: sample tx_o on every tick while busy, decode when busy falls.
    initial begin
        logic samples [0:255];
        int   nticks, gap_ticks, last_gap, bad;
        bit   in_frame, busy_prev;
        logic fgrant, req_bit;
        logic [7:0] d;
        exp_t e;
        nticks = 0; gap_ticks = 0; last_gap = 0; in_frame = 0; busy_prev = 0; fgrant = 0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                in_frame  = 0;
                busy_prev = 0;
                gap_ticks = 0;
            end else begin
                if (busy_o && !busy_prev) begin
                    in_frame = 1;
                    nticks   = 0;
                    fgrant   = grant_o;
                    last_gap = gap_ticks;
                end
                if (busy_o && tick_i && nticks < 256) begin
                    samples[nticks] = tx_o;
                    nticks++;
                end
                if (!busy_o && tick_i) gap_ticks++;
                if (!busy_o && busy_prev && in_frame) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", nticks, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_len", nticks, e.len);
                        for (int i = 0; i < 8; i++) d[i] = samples[16 * (i + 1)];
                        check("frame_data", int'(d), int'(e.data));
                        check("frame_grant", int'(fgrant), int'(e.grant));
                        bad = 0;
                        for (int k = 0; k < nticks; k++) begin
                            if (k < 16)                        req_bit = 1'b0;
                            else if (k < 144)                  req_bit = e.data[(k - 16) / 16];
`ifdef UART_TX_PARITY_EN
                            else if (k < 160)                  req_bit = ^e.data;
`endif
                            else                               req_bit = 1'b1;
                            if (samples[k] !== req_bit) bad++;
                        end
                        check("frame_waveform", bad, 0);
`ifdef UART_TX_PARITY_EN
                        check("parity_bit", int'(samples[144]), int'(^e.data));
`endif
                        if (e.chk_gap) check("idle_gap", last_gap, 0);
                    end
                    in_frame  = 0;
                    gap_ticks = 0;
                end
                busy_prev = busy_o;
            end
        end
    end

    task automatic push_exp(input logic [7:0] data, input logic grant, input bit chk_gap);
        exp_t e;
        e.data = data; e.grant = grant; e.len = FLEN; e.chk_gap = chk_gap;
        exp_q.push_back(e);
    endtask

    // Offer one byte, wait for the handshake, and check the one-cycle ready and line response.
    task automatic send(input int req, input logic [7:0] data, input bit expect_frame);
        bit got;
        if (expect_frame) push_exp(data, req[0], 1'b0);
        @(posedge clk_i);
        #1;
        if (req == 0) begin req0_valid_i = 1'b1; req0_data_i = data; end
        else          begin req1_valid_i = 1'b1; req1_data_i = data; end
        got = 0;
        for (int c = 0; c < 3000 && !got; c++) begin
            @(negedge clk_i);
            if ((req == 0 && req0_ready_o) || (req == 1 && req1_ready_o)) got = 1;
        end
        if (!got) timeout("send_ready");
        @(posedge clk_i);
        #1;
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        @(negedge clk_i);
        check("ready_pulse", int'(req0_ready_o | req1_ready_o), 0);
        check("busy_after_hs", int'(busy_o), 1);
        check("tx_start", int'(tx_o), 0);
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(negedge clk_i); while (!tick_i);
        end
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 0;
        for (int c = 0; c < 5000 && !done; c++) begin
            @(negedge clk_i);
            if (!busy_o && exp_q.size() == 0) done = 1;
        end
        if (!done) timeout(name);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   hs, stall_bad;
        logic held_tx;

        // Reset with requesters quiet.
        rst_ni = 1'b0; req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        req0_data_i = 8'h00; req1_data_i = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("rst_tx", int'(tx_o), 1);
            check("rst_busy", int'(busy_o), 0);
            check("rst_ready", int'({req0_ready_o, req1_ready_o}), 0);
            check("rst_grant", int'(grant_o), 0);
        end
        @(posedge clk_i); #1 rst_ni = 1'b1;
        @(negedge clk_i);
        check("post_rst_tx", int'(tx_o), 1);
        check("post_rst_busy", int'(busy_o), 0);
        check("post_rst_grant", int'(grant_o), 0);

        // Single byte from requester 0.
        send(0, 8'hA5, 1'b1);
        wait_idle("single_idle");

        // Contention from reset: 0x11, 0x22, 0x11, 0x22 back to back.
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        req0_valid_i = 1'b1; req0_data_i = 8'h11;
        req1_valid_i = 1'b1; req1_data_i = 8'h22;
        @(negedge clk_i);
        check("rst_ready_valid", int'({req0_ready_o, req1_ready_o}), 0);
        @(posedge clk_i); #1 rst_ni = 1'b1;
        push_exp(8'h11, 1'b0, 1'b0);
        push_exp(8'h22, 1'b1, 1'b1);
        push_exp(8'h11, 1'b0, 1'b1);
        push_exp(8'h22, 1'b1, 1'b1);
        hs = 0;
        for (int c = 0; c < 4000 && hs < 4; c++) begin
            @(negedge clk_i);
            if (req0_ready_o && req1_ready_o) check("ready_exclusive", 1, 0);
            if (req0_ready_o || req1_ready_o) hs++;
        end
        if (hs < 4) timeout("contention_hs");
        @(posedge clk_i); #1;
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        wait_idle("contention_idle");

        // Tick stall in the middle of DATA.
        send(1, 8'h3C, 1'b1);
        wait_ticks(40);
        tick_en = 1'b0;
        @(negedge clk_i);
        held_tx = tx_o;
        stall_bad = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk_i);
            if (tx_o !== held_tx || busy_o !== 1'b1) stall_bad++;
        end
        check("stall_frozen", stall_bad, 0);
        tick_en = 1'b1;
        wait_idle("stall_idle");

        // Reset during bit 3 of 0x5A; the frame is dropped, then resubmitted.
        send(0, 8'h5A, 1'b0);
        wait_ticks(72);
        rst_ni = 1'b0;
        #1;
        check("abort_tx", int'(tx_o), 1);
        check("abort_busy", int'(busy_o), 0);
        repeat (3) @(negedge clk_i);
        check("abort_ready", int'({req0_ready_o, req1_ready_o}), 0);
        @(posedge clk_i); #1 rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        check("abort_no_retry", int'(busy_o), 0);
        send(0, 8'h5A, 1'b1);
        wait_idle("resubmit_idle");

        // Parity frame (parity of 0x07 is 1 when compiled in).
        send(0, 8'h07, 1'b1);
        wait_idle("parity_idle");

        repeat (4) @(negedge clk_i);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Two-requester UART transmit scheduler for the Basys3 UART path. It accepts bytes from two independent sources over valid/ready handshakes and arbitrates between them round-robin. The granted byte is serialized onto a single `tx` line as an 8N1 frame. Bit timing comes entirely from the 16x-oversampling `tick` pulse of `baud_rate_generator`; the block contains no divisor of its own.

## Interface
- `DBIT`, 8: data bits per frame, LSB first.
- `SB_TICK`, 16: stop-bit length in ticks (16 = 1 stop bit, 32 = 2).
- `clk`  in  1  system clock (100 MHz on board).
- `rst`  in  1  asynchronous, active-low reset.
- `tick`  in  1  one-`clk` pulse from `baud_rate_generator`, 16 per bit period.
- `req0_valid`  in  1  requester 0 holds a byte.
- `req0_data`  in  DBIT  requester 0 byte.
- `req0_ready`  out  1  requester 0 byte accepted this cycle.
- `req1_valid`, `req1_data`, `req1_ready`: same as requester 0, for requester 1.
- `tx`  out  1  serial line, idle high, registered.
- `busy`  out  1  frame in progress (state != IDLE).
- `grant`  out  1  index of the requester whose byte is on the line; holds its value after the frame ends.

## Operation
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
- Ready logic in IDLE only (combinational):
  - `req0_ready = valid0 & (!valid1 | last==1)`.
  - `req1_ready = valid1 & (!valid0 | last==0)`.
- `last` is the round-robin pointer. It resets to 1, so requester 0 wins the first contention.
- Transfer occurs when valid & ready. On transfer:
  - Latch the byte into the shift register.
  - Set `last` and `grant` to the served index.
  - Clear the tick counter (4 bits) and the bit counter.
  - Go to START.
- Ready is 0 in every state other than IDLE. Valid is ignored there.
- A requester must hold data stable while valid and not ready. Dropping valid before ready is legal: no transfer occurs and no state is kept.
- START: `tx`=0. On the tick where the counter is 15, clear the counter and go to DATA.
- DATA: `tx` = shift[0]. On the tick where the counter is 15:
  - Shift right.
  - If the bit counter equals DBIT-1, go to PARITY (macro) or STOP.
  - Otherwise increment the bit counter.
- STOP: `tx`=1. On the tick where the counter is SB_TICK-1, go to IDLE.
- The counter advances only on `tick`. With no tick, all state holds indefinitely.
- Reset values: `tx`=1, `busy`=0, `req0_ready`=0, `req1_ready`=0, `grant`=0, `last`=1, state IDLE, counters 0, shift register 0.
- Reset asserted mid-frame: `tx` goes to 1 asynchronously and the frame is discarded. No retry and no ready is re-issued; the requester must resubmit.

## Timing
- Handshake in cycle T means `tx` falls at T+1 and `busy` rises at T+1.
- The START bit spans exactly 16 ticks, measured from the first tick after T+1.
- Frame length:
  - Without the macro: 16·(1+DBIT) + SB_TICK ticks (160 by default).
  - With the macro: 16·(2+DBIT) + SB_TICK ticks (176 by default).
- `busy` falls on the `clk` after the final stop tick. The earliest next handshake is that same cycle, giving zero idle ticks between back-to-back frames.
- A `tick` coinciding with the handshake cycle is not counted.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state is compiled in after DATA. It drives `tx` = XOR of the DBIT data bits (even parity) for 16 ticks, then goes to STOP.
- Not defined: PARITY state and the parity register are absent, and DATA goes directly to STOP.

## Test plan
All scenarios use `tick` every 4 `clk` and default parameters.
- Reset: hold `rst`=0 for 3 cycles, then release. Required: `tx`=1, `busy`=0, both readies 0, and `grant`=0 throughout and after.
- Single byte: `req0_valid`=1 with 0xA5. Required:
  - `req0_ready` pulses for 1 cycle.
  - `tx` carries 0, then bits 1,0,1,0,0,1,0,1 (LSB first), then 1.
  - Each bit lasts 16 ticks; `busy` lasts 160 ticks.
- Contention: both valid from reset, req0=0x11 and req1=0x22. Required:
  - Frames are sent in the order 0x11, 0x22, 0x11, 0x22.
  - `grant` reads 0, 1, 0, 1.
  - There are no idle ticks between frames.
- Tick stall: stop `tick` for 500 cycles in the middle of DATA. Required: `tx` and the state are frozen, and the frame resumes and completes correctly afterward.
- Mid-frame reset: assert `rst` at bit 3 of 0x5A. Required: `tx`=1 immediately and `busy`=0. After release, a resubmitted 0x5A is transmitted intact.
- Parity (macro on): send 0x07. Required: the parity bit is 1 and the frame is 176 ticks long. With the macro off, the frame is 160 ticks long.
